// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority-vote sampling, error/break detection and show-ahead FIFO
module uart_rx_os #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic                         rx_valid,
    output logic [DATA_BITS-1:0]         rx_data,
    output logic                         rx_frame_err,
    output logic                         rx_parity_err,
    output logic                         overrun,
    output logic                         break_det,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int BW  = $clog2(DATA_BITS) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FW  = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q;
    logic [1:0]           sync_q;
    logic [SW-1:0]        sc_q, sc_d;
    logic [1:0]           smp_q, smp_d;
    logic [BW-1:0]        bi_q, bi_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d, par_bit_q, par_bit_d;
    logic                 frame_err_q, frame_err_d, stop0_q, stop0_d;
    logic                 tick, rxs, vote, decide, fe_now, first_stop, push, brk;
    logic [FW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, rd_q;
    logic [AW:0]          count_q;
    logic                 full, pop, wr;

    assign tick   = div_q == DW'(DIV - 1);
    assign rxs    = sync_q[1];
    assign vote   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign decide = tick && sc_q == SW'(M + 1);

    // free-running oversample tick, never re-phased by the line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else div_q <= tick ? '0 : div_q + DW'(1);
    end

    // two-flop synchroniser, reset to the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], rx};
    end

    // FSM state and frame datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sc_q        <= '0;
            smp_q       <= '0;
            bi_q        <= '0;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            par_bit_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop0_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sc_q        <= sc_d;
            smp_q       <= smp_d;
            bi_q        <= bi_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            par_bit_q   <= par_bit_d;
            frame_err_q <= frame_err_d;
            stop0_q     <= stop0_d;
        end
    end

    // next-state: sample counter, vote capture, bit decisions and push/break generation
    always_comb begin
        state_d     = state_q;
        sc_d        = sc_q;
        smp_d       = smp_q;
        bi_d        = bi_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        par_bit_d   = par_bit_q;
        frame_err_d = frame_err_q;
        stop0_d     = stop0_q;
        push        = 1'b0;
        brk         = 1'b0;
        fe_now      = frame_err_q | ~vote;
        first_stop  = bi_q == '0 ? vote : stop0_q;
        if (state_q != IDLE && state_q != BREAK && tick) begin
            sc_d = sc_q == SW'(OVERSAMPLE - 1) ? '0 : sc_q + SW'(1);
            if (sc_q == SW'(M - 1)) smp_d[0] = rxs;
            if (sc_q == SW'(M)) smp_d[1] = rxs;
        end
        case (state_q)
            IDLE: if (tick && !rxs) begin
                state_d     = START;
                sc_d        = '0;
                bi_d        = '0;
                frame_err_d = 1'b0;
                par_err_d   = 1'b0;
                par_bit_d   = 1'b0;
            end
            START: if (decide) state_d = vote ? IDLE : DATA;
            DATA: if (decide) begin
                data_d = {vote, data_q[DATA_BITS-1:1]};
                bi_d   = bi_q + BW'(1);
                if (bi_q == BW'(DATA_BITS - 1)) begin
                    bi_d    = '0;
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: if (decide) begin
                par_bit_d = vote;
                par_err_d = ^data_q ^ vote ^ PARITY_ODD;
                state_d   = STOP;
            end
            STOP: if (decide) begin
                frame_err_d = fe_now;
                stop0_d     = first_stop;
                bi_d        = bi_q + BW'(1);
                if (bi_q == BW'(STOP_BITS - 1)) begin
                    brk     = data_q == '0 && !par_bit_q && !first_stop;
                    push    = !brk;
                    state_d = brk ? BREAK : IDLE;
                end
            end
            BREAK: if (tick && rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign full = count_q == (AW + 1)'(FIFO_DEPTH);
    assign pop  = rd_en && count_q != '0;
    assign wr   = push && (!full || pop);

    // FIFO storage; word is {parity_err, frame_err, data}
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q] <= {par_err_q, fe_now, data_q};
    end

    // FIFO pointers, occupancy and registered event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            wr_q      <= wr_q + AW'(wr);
            rd_q      <= rd_q + AW'(pop);
            count_q   <= count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
            overrun   <= push && full && !pop;
            break_det <= brk;
        end
    end

    assign rx_valid   = count_q != '0;
    assign fifo_count = count_q;
    assign {rx_parity_err, rx_frame_err, rx_data} = rx_valid ? mem_q[rd_q] : '0;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench for uart_rx_os (8N1, 8E1 and 5N2 instances)
module tb_uart_rx_os;
    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0, rd2 = 1'b0;
    int         sel = 0;
    int         n_cmp = 0, n_bad = 0;
    logic       rx0, rx1, rx2;
    logic       v0, fe0, pe0, ov0, bk0, v1, fe1, pe1, ov1, bk1, v2, fe2, pe2, ov2, bk2;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [2:0] c0, c1, c2;
    int         ov_cnt0 = 0, bk_cnt0 = 0;

    assign rx0 = sel == 0 ? line : 1'b1;
    assign rx1 = sel == 1 ? line : 1'b1;
    assign rx2 = sel == 2 ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd0), .rx_valid(v0), .rx_data(d0),
        .rx_frame_err(fe0), .rx_parity_err(pe0), .overrun(ov0), .break_det(bk0), .fifo_count(c0));

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .rx_valid(v1), .rx_data(d1),
        .rx_frame_err(fe1), .rx_parity_err(pe1), .overrun(ov1), .break_det(bk1), .fifo_count(c1));

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16), .DATA_BITS(5),
                 .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .rx(rx2), .rd_en(rd2), .rx_valid(v2), .rx_data(d2),
        .rx_frame_err(fe2), .rx_parity_err(pe2), .overrun(ov2), .break_det(bk2), .fifo_count(c2));

    // count single-cycle event pulses on the 8N1 instance
    always @(negedge clk) begin
        if (ov0) ov_cnt0++;
        if (bk0) bk_cnt0++;
    end

    // hard bound on total run length
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run did not finish within 90000 cycles");
        $fatal(1);
    end

    task automatic drive(input logic b, input int n);
        line = b;
        repeat (n) @(negedge clk);
    endtask

    // start, LSB-first data (optional glitch inside bit gb), optional parity, stop bit(s)
    task automatic send_frame(input logic [8:0] d, input int nd, input int pen, input logic pb,
                              input logic s1, input logic s2, input int ns, input int gb);
        drive(1'b0, BIT);
        for (int i = 0; i < nd; i++) begin
            if (i == gb) begin
                drive(d[i], 75);
                drive(~d[i], 10);
                drive(d[i], 75);
            end else drive(d[i], BIT);
        end
        if (pen != 0) drive(pb, BIT);
        drive(s1, BIT);
        if (ns == 2) drive(s2, BIT);
        line = 1'b1;
    endtask

    task automatic pop(input int k);
        @(negedge clk);
        rd0 = k == 0;
        rd1 = k == 1;
        rd2 = k == 2;
        @(negedge clk);
        rd0 = 1'b0;
        rd1 = 1'b0;
        rd2 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", v0); end
        n_cmp++; if (d0 !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", d0); end
        n_cmp++; if (c0 !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", c0); end
        n_cmp++; if ({fe0, pe0, ov0, bk0} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {fe0, pe0, ov0, bk0}); end
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_8n1;
        sel = 0;
        send_frame(9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL 8n1_valid: got %b want 1", v0); end
        n_cmp++; if (d0 !== 8'hA5) begin n_bad++; $display("FAIL 8n1_data: got %h want a5", d0); end
        n_cmp++; if ({fe0, pe0} !== 2'b00) begin n_bad++; $display("FAIL 8n1_errs: got %b want 00", {fe0, pe0}); end
        n_cmp++; if (c0 !== 3'd1) begin n_bad++; $display("FAIL 8n1_count: got %0d want 1", c0); end
        pop(0);
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL 8n1_pop_valid: got %b want 0", v0); end
    endtask

    task automatic test_glitch;
        sel = 0;
        drive(1'b0, 40);
        drive(1'b1, 2 * BIT);
        n_cmp++; if (c0 !== 3'd0) begin n_bad++; $display("FAIL glitch_false_start: count got %0d want 0", c0); end
        send_frame(9'h03C, 8, 0, 1'b0, 1'b1, 1'b1, 1, 2);
        n_cmp++; if (d0 !== 8'h3C) begin n_bad++; $display("FAIL glitch_data: got %h want 3c", d0); end
        n_cmp++; if (c0 !== 3'd1) begin n_bad++; $display("FAIL glitch_count: got %0d want 1", c0); end
        pop(0);
        drive(1'b1, BIT);
    endtask

    task automatic test_parity;
        sel = 1;
        send_frame(9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (d1 !== 8'h07) begin n_bad++; $display("FAIL par_bad_data: got %h want 07", d1); end
        n_cmp++; if (pe1 !== 1'b1) begin n_bad++; $display("FAIL par_bad_flag: got %b want 1", pe1); end
        n_cmp++; if (fe1 !== 1'b0) begin n_bad++; $display("FAIL par_bad_fe: got %b want 0", fe1); end
        pop(1);
        send_frame(9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (pe1 !== 1'b0) begin n_bad++; $display("FAIL par_good_flag: got %b want 0", pe1); end
        n_cmp++; if (c1 !== 3'd1) begin n_bad++; $display("FAIL par_good_count: got %0d want 1", c1); end
        pop(1);
        drive(1'b1, BIT);
    endtask

    task automatic test_framing_break;
        int bk_snap;
        sel = 0;
        send_frame(9'h055, 8, 0, 1'b0, 1'b0, 1'b1, 1, -1);
        n_cmp++; if (d0 !== 8'h55) begin n_bad++; $display("FAIL frame_data: got %h want 55", d0); end
        n_cmp++; if (fe0 !== 1'b1) begin n_bad++; $display("FAIL frame_err: got %b want 1", fe0); end
        drive(1'b1, 2 * BIT);
        n_cmp++; if (c0 !== 3'd1) begin n_bad++; $display("FAIL frame_count: got %0d want 1", c0); end
        pop(0);
        bk_snap = bk_cnt0;
        drive(1'b0, 20 * BIT);
        drive(1'b1, 2 * BIT);
        n_cmp++; if (bk_cnt0 - bk_snap !== 1) begin n_bad++; $display("FAIL break_pulses: got %0d want 1", bk_cnt0 - bk_snap); end
        n_cmp++; if (c0 !== 3'd0) begin n_bad++; $display("FAIL break_no_push: count got %0d want 0", c0); end
        send_frame(9'h081, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (d0 !== 8'h81) begin n_bad++; $display("FAIL after_break_data: got %h want 81", d0); end
        n_cmp++; if ({fe0, c0} !== 4'b0001) begin n_bad++; $display("FAIL after_break_fe_count: got %b want 0001", {fe0, c0}); end
        pop(0);
    endtask

    task automatic test_overrun;
        int ov_snap;
        sel = 0;
        ov_snap = ov_cnt0;
        for (int i = 1; i <= 5; i++) send_frame(9'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (c0 !== 3'd4) begin n_bad++; $display("FAIL ovr_count: got %0d want 4", c0); end
        n_cmp++; if (ov_cnt0 - ov_snap !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt0 - ov_snap); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (d0 !== 8'(i)) begin n_bad++; $display("FAIL ovr_read%0d: got %h want %h", i, d0, 8'(i)); end
            pop(0);
        end
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL ovr_drained: valid got %b want 0", v0); end
    endtask

    task automatic test_full_rd;
        int  ov_snap;
        logic hit;
        sel = 0;
        hit = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(9'(i), 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        ov_snap = ov_cnt0;
        fork
            send_frame(9'h005, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
            for (int t = 0; t < 20 * BIT && !hit; t++) begin
                @(negedge clk);
                if (u0.push) begin
                    rd0 = 1'b1;
                    hit = 1'b1;
                    @(negedge clk);
                    rd0 = 1'b0;
                end
            end
        join
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL fullrd_push_seen: got %b want 1", hit); end
        n_cmp++; if (ov_cnt0 - ov_snap !== 0) begin n_bad++; $display("FAIL fullrd_overrun: got %0d want 0", ov_cnt0 - ov_snap); end
        n_cmp++; if (c0 !== 3'd4) begin n_bad++; $display("FAIL fullrd_count: got %0d want 4", c0); end
        for (int i = 2; i <= 5; i++) begin
            n_cmp++; if (d0 !== 8'(i)) begin n_bad++; $display("FAIL fullrd_read%0d: got %h want %h", i, d0, 8'(i)); end
            pop(0);
        end
    endtask

    task automatic test_reset_mid;
        sel = 0;
        send_frame(9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        drive(1'b0, BIT);
        drive(1'b1, BIT);
        drive(1'b0, BIT);
        drive(1'b1, 60);
        rst = 1'b1;
        #1;
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", v0); end
        n_cmp++; if (d0 !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", d0); end
        n_cmp++; if (c0 !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", c0); end
        line = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2 * BIT);
        send_frame(9'h0F0, 8, 0, 1'b0, 1'b1, 1'b1, 1, -1);
        n_cmp++; if (d0 !== 8'hF0) begin n_bad++; $display("FAIL rstmid_next_data: got %h want f0", d0); end
        n_cmp++; if ({fe0, pe0, c0} !== 5'b00001) begin n_bad++; $display("FAIL rstmid_next_flags: got %b want 00001", {fe0, pe0, c0}); end
        pop(0);
    endtask

    task automatic test_5n2;
        sel = 2;
        send_frame(9'h01B, 5, 0, 1'b0, 1'b1, 1'b1, 2, -1);
        n_cmp++; if (d2 !== 5'h1B) begin n_bad++; $display("FAIL 5n2_data: got %h want 1b", d2); end
        n_cmp++; if (fe2 !== 1'b0) begin n_bad++; $display("FAIL 5n2_fe_clean: got %b want 0", fe2); end
        pop(2);
        send_frame(9'h01B, 5, 0, 1'b0, 1'b1, 1'b0, 2, -1);
        n_cmp++; if (d2 !== 5'h1B) begin n_bad++; $display("FAIL 5n2_bad_stop_data: got %h want 1b", d2); end
        n_cmp++; if (fe2 !== 1'b1) begin n_bad++; $display("FAIL 5n2_bad_stop_fe: got %b want 1", fe2); end
        pop(2);
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_glitch;
        test_parity;
        test_framing_break;
        test_overrun;
        test_full_rd;
        test_reset_mid;
        test_5n2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
